// File: rtl/roic_tx_framer.sv
// ---------------------------------------------------------------------------
// roic_tx_framer
//   Serialises 24-bit ROIC words into three bytes, one per clk_div cycle, for
//   a downstream 8:1 DDR OSERDESE2. A parallel frame lane carries FF,F0,00 so
//   the receiver's frame-clock rising edge always marks a word's MSB byte.
//   When no word is accepted at a word boundary, IDLE_WORD is sent instead.
//
// Ports
//   clk_div      in   byte clock (posedge only)
//   rst_n        in   asynchronous active-low reset
//   tx_en        in   enables word acceptance
//   word_in      in   parallel word to transmit
//   word_valid   in   word_in is valid
//   word_ready   out  word accepted this cycle when word_valid is also high
//   tx_byte      out  data byte to OSERDESE2 D inputs, bit 7 first
//   tx_frame     out  frame-clock byte to frame-lane OSERDESE2, bit 7 first
//   underrun_cnt out  saturating count of idle insertions while tx_en=1
//   word_cnt     out  wrapping count of accepted words
// ---------------------------------------------------------------------------
module roic_tx_framer #(
    parameter int                   WORD_SIZE = 24,
    parameter int                   DEV_W     = 8,
    parameter logic [WORD_SIZE-1:0] IDLE_WORD = 24'hA5_5A_C3
) (
    input  logic                 clk_div,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic [WORD_SIZE-1:0] word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    output logic [DEV_W-1:0]     tx_byte,
    output logic [DEV_W-1:0]     tx_frame,
    output logic [15:0]          underrun_cnt,
    output logic [15:0]          word_cnt
);

    localparam logic [DEV_W-1:0] FRAME_MSB = '1;
    localparam logic [DEV_W-1:0] FRAME_MID = {{(DEV_W/2){1'b1}}, {(DEV_W/2){1'b0}}};
    localparam logic [DEV_W-1:0] FRAME_LSB = '0;

    // idx names the byte currently on tx_byte; 2 means the LSB is out and the
    // next edge starts a new word.
    logic [1:0]           idx;
    logic [WORD_SIZE-1:0] cur_word;
    logic [WORD_SIZE-1:0] load_word;
    logic                 handshake;

    always_comb begin
        word_ready = (idx == 2'd2) & tx_en;
        handshake  = word_ready & word_valid;
        load_word  = handshake ? word_in : IDLE_WORD;
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= 2'd2;
            cur_word     <= IDLE_WORD;
            tx_byte      <= '0;
            tx_frame     <= '0;
            underrun_cnt <= '0;
            word_cnt     <= '0;
        end else begin
            case (idx)
                2'd2: begin
                    // MSB goes out directly from the loaded word, so it
                    // appears on the same edge as the handshake.
                    cur_word <= load_word;
                    tx_byte  <= load_word[WORD_SIZE-1 -: DEV_W];
                    tx_frame <= FRAME_MSB;
                    idx      <= 2'd0;
                    if (handshake)
                        word_cnt <= word_cnt + 16'd1;
                    if (tx_en && !word_valid && (underrun_cnt != '1))
                        underrun_cnt <= underrun_cnt + 16'd1;
                end
                2'd0: begin
                    tx_byte  <= cur_word[WORD_SIZE-DEV_W-1 -: DEV_W];
                    tx_frame <= FRAME_MID;
                    idx      <= 2'd1;
                end
                2'd1: begin
                    tx_byte  <= cur_word[DEV_W-1:0];
                    tx_frame <= FRAME_LSB;
                    idx      <= 2'd2;
                end
                default: begin
                    // Illegal index: realign to a word boundary.
                    idx <= 2'd2;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_roic_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_roic_tx_framer
//   Directed self-checking bench for roic_tx_framer. Inputs change and
//   outputs are sampled 1 ns after each rising edge of clk_div.
// ---------------------------------------------------------------------------
module tb_roic_tx_framer;

    logic        clk_div;
    logic        rst_n;
    logic        tx_en;
    logic [23:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  tx_byte;
    logic [7:0]  tx_frame;
    logic [15:0] underrun_cnt;
    logic [15:0] word_cnt;

    int total = 0;
    int bad   = 0;

    roic_tx_framer #(
        .WORD_SIZE (24),
        .DEV_W     (8),
        .IDLE_WORD (24'hA5_5A_C3)
    ) dut (
        .clk_div      (clk_div),
        .rst_n        (rst_n),
        .tx_en        (tx_en),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .tx_byte      (tx_byte),
        .tx_frame     (tx_frame),
        .underrun_cnt (underrun_cnt),
        .word_cnt     (word_cnt)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    // Reset asserted, then released on a falling edge so the first active
    // edge afterwards is half a period away.
    task automatic do_reset(input logic en, input logic vld, input logic [23:0] w);
        rst_n      = 1'b0;
        tx_en      = en;
        word_valid = vld;
        word_in    = w;
        #12;
        @(negedge clk_div);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        tx_en      = 1'b1;
        word_valid = 1'b0;
        word_in    = 24'h0;
        #12;
        total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", tx_byte); end
        total++; if (tx_frame !== 8'h00) begin bad++; $display("FAIL reset_frame got=%h exp=00", tx_frame); end
        total++; if (underrun_cnt !== 16'h0) begin bad++; $display("FAIL reset_underrun got=%h exp=0000", underrun_cnt); end
        total++; if (word_cnt !== 16'h0) begin bad++; $display("FAIL reset_wordcnt got=%h exp=0000", word_cnt); end
        total++; if (word_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_en got=%b exp=1", word_ready); end
        tx_en = 1'b0;
        #1;
        total++; if (word_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_dis got=%b exp=0", word_ready); end
    endtask

    task automatic test_first_word();
        logic [7:0] eb [3];
        logic [7:0] ef [3];
        eb[0] = 8'h12; eb[1] = 8'h34; eb[2] = 8'h56;
        ef[0] = 8'hFF; ef[1] = 8'hF0; ef[2] = 8'h00;
        do_reset(1'b1, 1'b1, 24'h123456);
        total++; if (word_ready !== 1'b1) begin bad++; $display("FAIL first_ready_after_rst got=%b exp=1", word_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            word_valid = 1'b0;
            total++; if (tx_byte !== eb[i]) begin bad++; $display("FAIL first_byte%0d got=%h exp=%h", i, tx_byte, eb[i]); end
            total++; if (tx_frame !== ef[i]) begin bad++; $display("FAIL first_frame%0d got=%h exp=%h", i, tx_frame, ef[i]); end
        end
        total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL first_wordcnt got=%0d exp=1", word_cnt); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL first_underrun got=%0d exp=0", underrun_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] eb [6];
        logic       er [6];
        eb[0] = 8'h11; eb[1] = 8'h11; eb[2] = 8'h11;
        eb[3] = 8'h22; eb[4] = 8'h22; eb[5] = 8'h22;
        er[0] = 1'b0; er[1] = 1'b0; er[2] = 1'b1;
        er[3] = 1'b0; er[4] = 1'b0; er[5] = 1'b1;
        do_reset(1'b1, 1'b1, 24'h111111);
        for (int i = 0; i < 6; i++) begin
            tick();
            // Next word presented while idx!=2; it must not be taken early.
            if (i == 0) word_in = 24'h222222;
            if (i == 5) word_valid = 1'b0;
            total++; if (tx_byte !== eb[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, tx_byte, eb[i]); end
            total++; if (word_ready !== er[i]) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=%b", i, word_ready, er[i]); end
            if (i == 2) begin
                total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL b2b_cnt_mid got=%0d exp=1", word_cnt); end
            end
        end
        total++; if (word_cnt !== 16'd2) begin bad++; $display("FAIL b2b_wordcnt got=%0d exp=2", word_cnt); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL b2b_underrun got=%0d exp=0", underrun_cnt); end
    endtask

    task automatic test_idle();
        logic [7:0] eb [3];
        logic [7:0] ef [3];
        eb[0] = 8'hA5; eb[1] = 8'h5A; eb[2] = 8'hC3;
        ef[0] = 8'hFF; ef[1] = 8'hF0; ef[2] = 8'h00;
        do_reset(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 9; i++) begin
            tick();
            total++; if (tx_byte !== eb[i % 3]) begin bad++; $display("FAIL idle_byte%0d got=%h exp=%h", i, tx_byte, eb[i % 3]); end
            total++; if (tx_frame !== ef[i % 3]) begin bad++; $display("FAIL idle_frame%0d got=%h exp=%h", i, tx_frame, ef[i % 3]); end
        end
        total++; if (underrun_cnt !== 16'd3) begin bad++; $display("FAIL idle_underrun got=%0d exp=3", underrun_cnt); end
        total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL idle_wordcnt got=%0d exp=0", word_cnt); end
    endtask

    task automatic test_tx_en_drop();
        logic [7:0] eb [6];
        eb[0] = 8'hAB; eb[1] = 8'hCD; eb[2] = 8'hEF;
        eb[3] = 8'hA5; eb[4] = 8'h5A; eb[5] = 8'hC3;
        do_reset(1'b1, 1'b1, 24'hABCDEF);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) tx_en = 1'b0;
            total++; if (tx_byte !== eb[i]) begin bad++; $display("FAIL drop_byte%0d got=%h exp=%h", i, tx_byte, eb[i]); end
            total++; if (word_ready !== 1'b0) begin bad++; $display("FAIL drop_ready%0d got=%b exp=0", i, word_ready); end
        end
        total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL drop_wordcnt got=%0d exp=1", word_cnt); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL drop_underrun got=%0d exp=0", underrun_cnt); end
    endtask

    task automatic test_saturation();
        do_reset(1'b1, 1'b0, 24'h0);
        #1;
        force dut.underrun_cnt = 16'hFFFE;
        #1;
        release dut.underrun_cnt;
        for (int i = 0; i < 9; i++) begin
            tick();
            if ((i % 3) == 0) begin
                total++; if (underrun_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_underrun%0d got=%h exp=FFFF", i, underrun_cnt); end
            end
        end
        force dut.word_cnt = 16'hFFFF;
        #1;
        release dut.word_cnt;
        word_valid = 1'b1;
        word_in    = 24'h010203;
        tick();
        word_valid = 1'b0;
        total++; if (word_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_wordcnt got=%h exp=0000", word_cnt); end
        total++; if (tx_byte !== 8'h01) begin bad++; $display("FAIL wrap_byte got=%h exp=01", tx_byte); end
        total++; if (underrun_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_underrun got=%h exp=FFFF", underrun_cnt); end
    endtask

    task automatic test_reset_mid_word();
        do_reset(1'b1, 1'b1, 24'h123456);
        tick();
        word_valid = 1'b0;
        tick();
        total++; if (tx_byte !== 8'h34) begin bad++; $display("FAIL rstmid_pre_byte got=%h exp=34", tx_byte); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL rstmid_byte got=%h exp=00", tx_byte); end
        total++; if (tx_frame !== 8'h00) begin bad++; $display("FAIL rstmid_frame got=%h exp=00", tx_frame); end
        total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_wordcnt got=%0d exp=0", word_cnt); end
        total++; if (word_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", word_ready); end
        word_valid = 1'b1;
        word_in    = 24'h789ABC;
        @(negedge clk_div);
        rst_n = 1'b1;
        tick();
        word_valid = 1'b0;
        total++; if (tx_byte !== 8'h78) begin bad++; $display("FAIL rstmid_resume_byte got=%h exp=78", tx_byte); end
        total++; if (tx_frame !== 8'hFF) begin bad++; $display("FAIL rstmid_resume_frame got=%h exp=FF", tx_frame); end
        total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL rstmid_resume_cnt got=%0d exp=1", word_cnt); end
        tick();
        total++; if (tx_byte !== 8'h9A) begin bad++; $display("FAIL rstmid_resume_b1 got=%h exp=9A", tx_byte); end
        tick();
        total++; if (tx_byte !== 8'hBC) begin bad++; $display("FAIL rstmid_resume_b2 got=%h exp=BC", tx_byte); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_back_to_back();
        test_idle();
        test_tx_en_drop();
        test_saturation();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roic_tx_framer.md
ROIC_TX_FRAMER -- requirements
Module: roic_tx_framer

Interface
- REQ-001 SHALL have parameter WORD_SIZE, default 24, which sets the parallel word width and is fixed at 24 for this block.
- REQ-002 SHALL have parameter DEV_W, default 8, which sets the byte width per clk_div cycle for the downstream 8:1 DDR OSERDESE2 and is fixed at 8.
- REQ-003 SHALL have parameter IDLE_WORD, default 24'hA5_5A_C3, which is the word sent when no data is accepted.
- REQ-004 SHALL have port clk_div  input  1  sole clock, divided/byte clock, posedge only.
- REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
- REQ-006 SHALL have port tx_en  input  1  enables word acceptance.
- REQ-007 SHALL have port word_in  input  24  parallel word to transmit.
- REQ-008 SHALL have port word_valid  input  1  word_in is valid.
- REQ-009 SHALL have port word_ready  output  1  word accepted this cycle when word_valid is also high.
- REQ-010 SHALL have port tx_byte  output  8  data byte to the OSERDESE2 D inputs, with bit 7 transmitted first.
- REQ-011 SHALL have port tx_frame  output  8  frame-clock byte to the frame-lane OSERDESE2, with bit 7 transmitted first.
- REQ-012 SHALL have port underrun_cnt  output  16  saturating count of idle insertions while tx_en=1.
- REQ-013 SHALL have port word_cnt  output  16  wrapping count of accepted words.

Function
- REQ-014 SHALL hold a 2-bit byte index idx ∈ {0,1,2} naming the byte currently on tx_byte; value 3 is illegal and SHALL recover to 2 on the next edge.
- REQ-015 SHALL drive word_ready combinationally as (idx==2) & tx_en; a handshake (word_valid & word_ready) occurs at most once per 3 cycles.
- REQ-016 At idx==2, SHALL load cur_word with word_in on handshake, else with IDLE_WORD; SHALL then set tx_byte<=loaded[23:16], tx_frame<=8'hFF, idx<=0.
- REQ-017 At idx==0, SHALL set tx_byte<=cur_word[15:8], tx_frame<=8'hF0, idx<=1.
- REQ-018 At idx==1, SHALL set tx_byte<=cur_word[7:0], tx_frame<=8'h00, idx<=2.
- REQ-019 The frame sequence FF,F0,00 SHALL run continuously regardless of tx_en or data, so the receiver's frame-clock rising edge always marks the MSB of a word.
- REQ-020 Latency: a word accepted at edge N SHALL appear as bytes [23:16],[15:8],[7:0] on tx_byte after edges N, N+1, N+2 respectively.
- REQ-021 Back-to-back words SHALL stream with no gap: one word per 3 cycles while word_valid stays high.
- REQ-022 SHALL increment underrun_cnt at idx==2 when tx_en=1 and word_valid=0, saturating at 16'hFFFF.
- REQ-023 SHALL increment word_cnt on each handshake, wrapping from 16'hFFFF to 0.
- REQ-024 tx_en falling mid-word SHALL NOT truncate the word in flight; it blocks only the next acceptance.
- REQ-025 word_valid asserted while idx≠2 SHALL be ignored, with no handshake and no counter change; the source SHALL hold word_in until the handshake.

Reset
- REQ-026 Assertion of rst_n=0 SHALL asynchronously force idx=2, cur_word=IDLE_WORD, tx_byte=8'h00, tx_frame=8'h00, underrun_cnt=0, word_cnt=0.
- REQ-027 word_ready SHALL equal tx_en in the first cycle after deassertion; reset asserted mid-word SHALL discard that word with no count change.

Verification
- REQ-028 Reset release with tx_en=1, word_valid=1, word_in=24'h123456 -> tx_byte 12,34,56 and tx_frame FF,F0,00 on the next 3 edges; word_cnt=1.
- REQ-029 Continuous valid words 24'h111111,24'h222222 -> bytes 11,11,11,22,22,22 with no idle gap; word_ready high every 3rd cycle.
- REQ-030 tx_en=1, word_valid=0 for 9 cycles -> IDLE_WORD bytes A5,5A,C3 repeated 3 times; underrun_cnt=3; frame pattern unbroken.
- REQ-031 tx_en dropped at idx==0 of word 24'hABCDEF -> AB,CD,EF completes; next word is IDLE_WORD; word_ready stays low.
- REQ-032 underrun_cnt forced near 16'hFFFE, then 3 more underruns -> holds 16'hFFFF; word_cnt at 16'hFFFF plus 1 handshake -> 0.
- REQ-033 rst_n pulsed low at idx==1 -> outputs 00/00 immediately; after release, normal framing resumes at MSB with counters 0.
